stream_widen: RTL and testbench

STREAM_WIDEN -- requirements
Module: stream_widen

---
 rtl/stream_widen.sv | 231 +++++++++++++++++++++++
 tb/tb_stream_widen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_widen.sv
// stream_widen: packs STREAM_OUT_MULTIPLIER narrow features into one wide
// output word, buffers words in a FIFO and drains them while the downstream
// reports space through stream_out_ready.
//
// Optional feature macro: STREAM_WIDEN_ERROR_FLAG_EN
//   defined   -> sticky 'error' output, set when a partial word is discarded
//                by an early stream_in_first or when a word is dropped
//                because the FIFO is full; cleared only by rst.
//   undefined -> no 'error' port and no error logic; the discard and drop
//                behaviour itself is identical.
//
// Pipeline, counted in rising edges after the edge that samples the feature
// completing a word (FIFO empty, ready high):
//   edge 0 : feature lands in the assembly register, word marked pending
//   edge 1 : pending word written into the FIFO
//   edge 2 : FIFO popped into the read register
//   edge 3 : read register copied to the output register (valid rises)
module stream_widen #(
    parameter int STREAM_WIDTH          = 8,
    parameter int STREAM_OUT_MULTIPLIER = 3,
    parameter int BUFFER_DEPTH          = 4,
    localparam int STREAM_OUT_WIDTH     = STREAM_WIDTH * STREAM_OUT_MULTIPLIER
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STREAM_WIDTH-1:0]     stream_in,
    input  logic                        stream_in_valid,
    input  logic                        stream_in_first,
    input  logic                        stream_in_last,
    output logic [STREAM_OUT_WIDTH-1:0] stream_out,
    output logic                        stream_out_valid,
    output logic                        stream_out_first,
    output logic                        stream_out_last,
    input  logic                        stream_out_ready
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
    ,
    output logic                        error
`endif
);

    localparam int LANE_W  = $clog2(STREAM_OUT_MULTIPLIER);
    localparam int LEVEL_W = BUFFER_DEPTH + 1;
    localparam int DEPTH   = 1 << BUFFER_DEPTH;
    // FIFO entry layout: {last, first, data}
    localparam int ENTRY_W = STREAM_OUT_WIDTH + 2;

    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(STREAM_OUT_MULTIPLIER - 1);
    localparam logic [LEVEL_W-1:0] FULL_LVL  = LEVEL_W'(DEPTH);

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic [STREAM_OUT_WIDTH-1:0] asm_q, asm_d;
    logic                        asm_first_q, asm_first_d;
    logic                        asm_last_q;
    logic                        wr_pend_q;

    logic [LANE_W-1:0]           eff_lane;
    logic                        close_word;

    // Place the incoming feature in its lane; a first flag always restarts
    // the word at lane 0, throwing away whatever partial word was pending.
    always_comb begin
        eff_lane    = lane_q;
        asm_d       = asm_q;
        asm_first_d = asm_first_q;
        close_word  = 1'b0;
        lane_d      = lane_q;

        if (stream_in_first) begin
            eff_lane = '0;
        end

        // Starting a new word clears every lane so a short word is zero-filled.
        if (eff_lane == '0) begin
            asm_d       = '0;
            asm_first_d = stream_in_first;
        end

        for (int i = 0; i < STREAM_OUT_MULTIPLIER; i++) begin
            if (eff_lane == LANE_W'(i)) begin
                asm_d[i*STREAM_WIDTH +: STREAM_WIDTH] = stream_in;
            end
        end

        close_word = (eff_lane == LAST_LANE) || stream_in_last;
        lane_d     = close_word ? '0 : eff_lane + LANE_W'(1);
    end

    // Assembly register and lane counter; only valid features advance them.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q      <= '0;
            asm_q       <= '0;
            asm_first_q <= 1'b0;
            asm_last_q  <= 1'b0;
            wr_pend_q   <= 1'b0;
        end else begin
            wr_pend_q <= stream_in_valid && close_word;
            if (stream_in_valid) begin
                lane_q      <= lane_d;
                asm_q       <= asm_d;
                asm_first_q <= asm_first_d;
                asm_last_q  <= stream_in_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [BUFFER_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LEVEL_W-1:0]      level_q, level_d;

    logic fifo_full;
    logic fifo_pop;
    logic fifo_push;

    // Push/pop decisions; a write into a full FIFO only succeeds when the
    // same edge frees an entry.
    always_comb begin
        fifo_full = (level_q == FULL_LVL);
        fifo_pop  = (level_q != '0) && stream_out_ready;
        fifo_push = wr_pend_q && (!fifo_full || fifo_pop);
        level_d   = level_q;
        if (fifo_push && !fifo_pop) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (fifo_pop && !fifo_push) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    // FIFO storage; contents need no reset because the pointers guard them.
    always_ff @(posedge clk) begin
        if (!rst && fifo_push) begin
            mem_q[wr_ptr_q] <= {asm_last_q, asm_first_q, asm_q};
        end
    end

    // FIFO pointers and fill level; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + BUFFER_DEPTH'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + BUFFER_DEPTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read and output registers
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]          rd_entry_q;
    logic                        rd_valid_q;
    logic [STREAM_OUT_WIDTH-1:0] out_data_q;
    logic                        out_valid_q;
    logic                        out_first_q;
    logic                        out_last_q;

    // Capture the popped entry; this stage is what gives the fixed latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_entry_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= fifo_pop;
            if (fifo_pop) begin
                rd_entry_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Present the word; flags are forced low whenever no word is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            out_first_q <= rd_valid_q && rd_entry_q[STREAM_OUT_WIDTH];
            out_last_q  <= rd_valid_q && rd_entry_q[STREAM_OUT_WIDTH+1];
            if (rd_valid_q) begin
                out_data_q <= rd_entry_q[STREAM_OUT_WIDTH-1:0];
            end
        end
    end

    assign stream_out       = out_data_q;
    assign stream_out_valid = out_valid_q;
    assign stream_out_first = out_first_q;
    assign stream_out_last  = out_last_q;

`ifdef STREAM_WIDEN_ERROR_FLAG_EN
    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
    logic error_q;
    logic word_discard;
    logic word_drop;

    // A discard is an early first flag; a drop is a write into a full FIFO
    // that no pop rescued.
    always_comb begin
        word_discard = stream_in_valid && stream_in_first && (lane_q != '0);
        word_drop    = wr_pend_q && fifo_full && !fifo_pop;
    end

    // Error stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (word_discard || word_drop) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`endif

endmodule

// File: tb/tb_stream_widen.sv
// Testbench for stream_widen (default parameters: 8-bit features, 3 per word,
// 16-entry FIFO). Expected words come from a feature-list model and are
// queued at issue time; a negedge monitor pops and compares each output word.
module tb_stream_widen;

    localparam int W  = 8;
    localparam int M  = 3;
    localparam int OW = W * M;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  stream_in;
    logic          stream_in_valid;
    logic          stream_in_first;
    logic          stream_in_last;
    logic [OW-1:0] stream_out;
    logic          stream_out_valid;
    logic          stream_out_first;
    logic          stream_out_last;
    logic          stream_out_ready;
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
    logic          dut_error;
`endif

    stream_widen dut (
        .clk              (clk),
        .rst              (rst),
        .stream_in        (stream_in),
        .stream_in_valid  (stream_in_valid),
        .stream_in_first  (stream_in_first),
        .stream_in_last   (stream_in_last),
        .stream_out       (stream_out),
        .stream_out_valid (stream_out_valid),
        .stream_out_first (stream_out_first),
        .stream_out_last  (stream_out_last),
        .stream_out_ready (stream_out_ready)
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
        ,
        .error            (dut_error)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] data;
        bit            first;
        bit            last;
        int            exp_cyc;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state: features of the word being collected
    logic [W-1:0] part[$];
    bit           part_first;
    bit           exp_err;
    int           words_pushed = 0;

    // monitor
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (stream_out_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got=%h first=%0b last=%0b expected no word",
                             stream_out, stream_out_first, stream_out_last);
                end else begin
                    e = expq.pop_front();
                    if (stream_out !== e.data || stream_out_first !== e.first ||
                        stream_out_last !== e.last) begin
                        errors++;
                        $display("FAIL word got=%h f=%0b l=%0b expected=%h f=%0b l=%0b",
                                 stream_out, stream_out_first, stream_out_last,
                                 e.data, e.first, e.last);
                    end
                    if (e.exp_cyc >= 0) begin
                        checks++;
                        if (cyc != e.exp_cyc) begin
                            errors++;
                            $display("FAIL latency got_cycle=%0d expected_cycle=%0d", cyc, e.exp_cyc);
                        end
                    end
                end
            end else begin
                checks++;
                if (stream_out_first !== 1'b0 || stream_out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_flags got first=%0b last=%0b expected 0 0",
                             stream_out_first, stream_out_last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        stream_in_valid = 1'b0;
        stream_in_first = 1'b0;
        stream_in_last  = 1'b0;
        repeat (n) tick();
    endtask

    // drive one feature for one cycle and update the model
    task automatic feed(input logic [W-1:0] d, input bit f, input bit l,
                        input bit keep, input bit lat);
        exp_t          x;
        logic [OW-1:0] w;
        stream_in       = d;
        stream_in_valid = 1'b1;
        stream_in_first = f;
        stream_in_last  = l;
        if (f && part.size() != 0) begin
            part.delete();
            exp_err = 1'b1;
        end
        if (part.size() == 0) part_first = f;
        part.push_back(d);
        if (part.size() == M || l) begin
            w = '0;
            for (int i = 0; i < part.size(); i++) w[i*W +: W] = part[i];
            x.data    = w;
            x.first   = part_first;
            x.last    = l;
            x.exp_cyc = lat ? cyc + 4 : -1;
            if (keep) begin
                expq.push_back(x);
                words_pushed++;
            end else begin
                exp_err = 1'b1;
            end
            part.delete();
        end
        tick();
        stream_in_valid = 1'b0;
        stream_in_first = 1'b0;
        stream_in_last  = 1'b0;
    endtask

    // reset for two edges with garbage on the inputs, which must be ignored
    task automatic do_reset();
        rst             = 1'b1;
        stream_in       = W'($urandom);
        stream_in_valid = 1'b1;
        stream_in_first = 1'b1;
        stream_in_last  = 1'b1;
        part.delete();
        expq.delete();
        exp_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        idle(0);
        checks++;
        if (stream_out_valid !== 1'b0 || stream_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b data=%h expected 0 0",
                     stream_out_valid, stream_out);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout remaining=%0d expected 0", expq.size());
        end
        idle(5);
    endtask

`ifdef STREAM_WIDEN_ERROR_FLAG_EN
    task automatic check_err(input string name);
        checks++;
        if (dut_error !== exp_err) begin
            errors++;
            $display("FAIL %s error got=%0b expected=%0b", name, dut_error, exp_err);
        end
    endtask
`endif

    initial begin
        rst              = 1'b1;
        stream_in        = '0;
        stream_in_valid  = 1'b0;
        stream_in_first  = 1'b0;
        stream_in_last   = 1'b0;
        stream_out_ready = 1'b1;
        exp_err          = 1'b0;
        part_first       = 1'b0;
        tick();
        do_reset();
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
        check_err("after_reset");
`endif

        // two full words, fixed latency
        feed(8'h11, 1, 0, 1, 1);
        feed(8'h22, 0, 0, 1, 1);
        feed(8'h33, 0, 0, 1, 1);
        feed(8'h44, 0, 0, 1, 1);
        feed(8'h55, 0, 0, 1, 1);
        feed(8'h66, 0, 1, 1, 1);
        wait_drain(50);

        // single-feature-pair word with zero fill
        feed(8'hA1, 1, 0, 1, 1);
        feed(8'hA2, 0, 1, 1, 1);
        wait_drain(50);

        // early first discards the partial word
        feed(8'h01, 1, 0, 1, 0);
        feed(8'h02, 0, 0, 1, 0);
        feed(8'h03, 1, 0, 1, 0);
        feed(8'h04, 0, 0, 1, 0);
        feed(8'h05, 0, 0, 1, 0);
        wait_drain(50);
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
        check_err("discard");
`endif

        // overflow: 17 words into a 16-entry FIFO
        do_reset();
        stream_out_ready = 1'b0;
        for (int k = 0; k < 17; k++)
            for (int j = 0; j < M; j++)
                feed(W'(k * M + j + 1), j == 0, 0, k < 16, 0);
        idle(4);
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
        check_err("overflow");
`endif
        stream_out_ready = 1'b1;
        wait_drain(100);

        // reset with a partial word and buffered words
        do_reset();
        stream_out_ready = 1'b0;
        for (int j = 0; j < 5 * M + 2; j++) feed(W'($urandom), 0, 0, 1, 0);
        idle(3);
        do_reset();
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
        check_err("mid_reset");
`endif
        stream_out_ready = 1'b1;
        idle(10);
        feed(8'h5A, 1, 0, 1, 1);
        feed(8'h5B, 0, 0, 1, 1);
        feed(8'h5C, 0, 0, 1, 1);
        wait_drain(50);

        // random traffic
        begin
            int target = words_pushed + 1000;
            int n = 0;
            bit f, l;
            while (words_pushed < target && n < 20000) begin
                stream_out_ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) < 6) begin
                    f = (part.size() == 0) ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 29) == 0);
                    l = ($urandom_range(0, 9) == 0);
                    feed(W'($urandom), f, l, 1, 0);
                end else begin
                    idle(1);
                end
                n++;
            end
            checks++;
            if (words_pushed < target) begin
                errors++;
                $display("FAIL random_budget words=%0d expected=%0d", words_pushed, target);
            end
        end
        stream_out_ready = 1'b1;
        wait_drain(200);
`ifdef STREAM_WIDEN_ERROR_FLAG_EN
        check_err("random");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle=%0d expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
